// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types, exception codes and the instruction queue entry
`ifndef FETCH_PKG_INT_DEFINED
`define FETCH_PKG_INT_DEFINED
`define Int 5'h00
`endif
package fetch_pkg;
   localparam logic [4:0] EXC_INT  = `Int;
   localparam logic [4:0] EXC_TLBL = 5'h02;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } Predict_Branch_S;
   typedef struct packed {
      logic        Vaild;
      logic [31:0] pc;
   } Recover_Decode_S;
   typedef struct packed {
      logic [31:0]     instr;
      logic [31:0]     pc;
      Predict_Branch_S bp_info;
      logic [4:0]      exc_code;
      logic            tre;
   } fq_entry_t;
endpackage

// File: rtl/fq_pair_select.sv
// fq_pair_select: builds a 1-2 instruction decode packet from the two head entries
module fq_pair_select
   import fetch_pkg::*;
#(
   parameter int CW = 4
) (
   input  fq_entry_t             e0_i,
   input  fq_entry_t             e1_i,
   input  logic [CW-1:0]         cnt_i,
   output logic [1:0]            valid_o,
   output logic [63:0]           instr_o,
   output logic [31:0]           pc_o,
   output Predict_Branch_S [1:0] bp_info_o,
   output logic [4:0]            exc_code_o,
   output logic                  tre_o
);
   logic v0, v1;
   assign v0 = cnt_i != '0;
   // pair only PC-consecutive entries that agree on exception status
   assign v1 = cnt_i >= CW'(2) && e1_i.pc == e0_i.pc + 32'd4 &&
               e1_i.exc_code == e0_i.exc_code && e1_i.tre == e0_i.tre;
   assign valid_o      = {v1, v0};
   assign instr_o      = {v1 ? e1_i.instr : 32'd0, v0 ? e0_i.instr : 32'd0};
   assign pc_o         = v0 ? e0_i.pc : 32'd0;
   assign bp_info_o[1] = v1 ? e1_i.bp_info : '0;
   assign bp_info_o[0] = v0 ? e0_i.bp_info : '0;
   assign exc_code_o   = v0 ? e0_i.exc_code : 5'd0;
   assign tre_o        = v0 & e0_i.tre;
endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: per-instruction fetch queue feeding decode with 1-2 instruction packets.
// Optional macro FETCH_QUEUE_BYPASS_EN presents an incoming group directly when the queue is empty.
module fetch_inst_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  Recover_Decode_S       recover_decode,
   input  logic [1:0]            in_valid,
   input  logic [63:0]           in_instr,
   input  logic [31:0]           in_pc,
   input  Predict_Branch_S [1:0] in_bp_info,
   input  logic [4:0]            in_exc_code,
   input  logic                  in_tre,
   output logic                  in_ready,
   input  logic                  allowin_D,
   output logic [1:0]            valid_F,
   output logic [63:0]           instr_F,
   output logic [31:0]           pc_F,
   output Predict_Branch_S [1:0] bp_info_F,
   output logic [4:0]            exc_code_F,
   output logic                  tre_F
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   fq_entry_t     mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d, sel_cnt;
   fq_entry_t     s0, s1, w0, e0, e1;
   logic [1:0]    wr_n, deq_n;
   logic          kill, enq, byp, unused;
   assign unused  = ^recover_decode.pc;
   assign s0      = '{instr: in_instr[31:0], pc: in_pc, bp_info: in_bp_info[0],
                      exc_code: in_exc_code, tre: in_tre};
   assign s1      = '{instr: in_instr[63:32], pc: in_pc + 32'd4, bp_info: in_bp_info[1],
                      exc_code: in_exc_code, tre: in_tre};
   assign w0      = in_valid[0] ? s0 : s1;
   assign wr_n    = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
   assign kill    = flush | recover_decode.Vaild;
   assign in_ready = cnt_q <= CW'(DEPTH - 2);
`ifdef FETCH_QUEUE_BYPASS_EN
   // a whole group always pairs, so a bypassed group is consumed entirely
   assign byp     = cnt_q == '0 && in_ready && allowin_D && !kill && |in_valid;
`else
   assign byp     = 1'b0;
`endif
   assign e0      = byp ? w0 : mem_q[head_q];
   assign e1      = byp ? s1 : mem_q[head_q + PW'(1)];
   assign sel_cnt = byp ? CW'(wr_n) : cnt_q;
   fq_pair_select #(.CW(CW)) u_sel (
      .e0_i      (e0),
      .e1_i      (e1),
      .cnt_i     (sel_cnt),
      .valid_o   (valid_F),
      .instr_o   (instr_F),
      .pc_o      (pc_F),
      .bp_info_o (bp_info_F),
      .exc_code_o(exc_code_F),
      .tre_o     (tre_F)
   );
   assign enq     = in_ready && |in_valid && !kill && !byp;
   assign deq_n   = (allowin_D && !byp) ? {1'b0, valid_F[0]} + {1'b0, valid_F[1]} : 2'd0;
   assign cnt_d   = kill ? '0 : cnt_q + (enq ? CW'(wr_n) : '0) - CW'(deq_n);
   assign head_d  = kill ? '0 : head_q + PW'(deq_n);
   assign tail_d  = kill ? '0 : tail_q + (enq ? PW'(wr_n) : '0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end
   always_ff @(posedge clk) begin
      if (enq) mem_q[tail_q] <= w0;
      if (enq && wr_n == 2'd2) mem_q[tail_q + PW'(1)] <= s1;
   end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: scoreboard bench; stimulus pushes accepted instructions, monitor checks packets
module tb_fetch_inst_queue;
   import fetch_pkg::*;
   localparam int DEPTH = 8;
   logic clk, rst, flush, in_ready, allowin_D, in_tre, tre_F;
   Recover_Decode_S recover_decode;
   logic [1:0] in_valid, valid_F;
   logic [63:0] in_instr, instr_F;
   logic [31:0] in_pc, pc_F, pcn;
   Predict_Branch_S [1:0] in_bp_info, bp_info_F;
   logic [4:0] in_exc_code, exc_code_F;
   fq_entry_t mq[$];
   int n_cmp = 0, n_bad = 0, pre_size = 0;

   fetch_inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .recover_decode(recover_decode),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_bp_info(in_bp_info),
      .in_exc_code(in_exc_code), .in_tre(in_tre), .in_ready(in_ready), .allowin_D(allowin_D),
      .valid_F(valid_F), .instr_F(instr_F), .pc_F(pc_F), .bp_info_F(bp_info_F),
      .exc_code_F(exc_code_F), .tre_F(tre_F)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // monitor: expected packet derived from the model queue contents
   always @(negedge clk) begin
      fq_entry_t a, b;
      logic [1:0] ev;
      a = '0;
      b = '0;
      if (mq.size() >= 1) a = mq[0];
      if (mq.size() >= 2) b = mq[1];
      ev[0] = mq.size() >= 1;
      ev[1] = mq.size() >= 2 && b.pc == a.pc + 32'd4 && b.exc_code == a.exc_code && b.tre == a.tre;
      chk("valid_F", 128'(valid_F), 128'(ev));
      chk("instr_F", 128'(instr_F), 128'({ev[1] ? b.instr : 32'd0, ev[0] ? a.instr : 32'd0}));
      chk("pc_F", 128'(pc_F), 128'(ev[0] ? a.pc : 32'd0));
      chk("exc_code_F", 128'(exc_code_F), 128'(ev[0] ? a.exc_code : 5'd0));
      chk("tre_F", 128'(tre_F), 128'(ev[0] & a.tre));
      chk("bp_info_F", 128'(bp_info_F), 128'({ev[1] ? b.bp_info : 33'd0, ev[0] ? a.bp_info : 33'd0}));
      chk("in_ready", 128'(in_ready), 128'((DEPTH - mq.size()) >= 2));
      pre_size = mq.size();
      if (allowin_D) begin
         if (ev[0]) void'(mq.pop_front());
         if (ev[1]) void'(mq.pop_front());
      end
   end

   task automatic cyc(input logic [1:0] v, input logic [31:0] pc, input logic [4:0] ex,
                      input logic al, input logic fl = 0, input logic rec = 0, input logic tr = 0);
      fq_entry_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      in_pc = pc;
      in_instr = {$urandom, $urandom};
      in_bp_info = {1'($urandom), $urandom, 1'($urandom), $urandom};
      in_exc_code = ex;
      in_tre = tr;
      allowin_D = al;
      flush = fl;
      recover_decode = '{Vaild: rec, pc: $urandom};
      @(negedge clk);
      #1;
      if (rst || fl || rec) mq.delete();
      else if ((DEPTH - pre_size) >= 2) begin
         if (v[0]) begin
            e = '{instr: in_instr[31:0], pc: pc, bp_info: in_bp_info[0], exc_code: ex, tre: tr};
            mq.push_back(e);
         end
         if (v[1]) begin
            e = '{instr: in_instr[63:32], pc: pc + 32'd4, bp_info: in_bp_info[1], exc_code: ex, tre: tr};
            mq.push_back(e);
         end
      end
   endtask

   initial begin
      rst = 1; flush = 0; recover_decode = '0; in_valid = 0; in_instr = 0; in_pc = 0;
      in_bp_info = '0; in_exc_code = 0; in_tre = 0; allowin_D = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      cyc(2'b11, 32'h1000, EXC_INT, 1);
      cyc(2'b00, 32'h0, EXC_INT, 1);
      cyc(2'b00, 32'h0, EXC_INT, 1);
      cyc(2'b10, 32'h2000, EXC_INT, 1);
      cyc(2'b00, 32'h0, EXC_INT, 1);
      cyc(2'b10, 32'h3000, EXC_INT, 0);
      cyc(2'b01, 32'h4000, EXC_INT, 0);
      repeat (3) cyc(2'b00, 32'h0, EXC_INT, 1);
      cyc(2'b01, 32'h5000, EXC_INT, 0);
      cyc(2'b10, 32'h5000, EXC_ADEL, 0);
      repeat (3) cyc(2'b00, 32'h0, EXC_INT, 1);
      for (int i = 0; i < 5; i++) cyc(2'b11, 32'h6000 + 32'(8 * i), EXC_INT, 0);
      cyc(2'b11, 32'h6020, EXC_INT, 0);
      repeat (3) cyc(2'b11, 32'h6020, EXC_INT, 1);
      repeat (4) cyc(2'b00, 32'h0, EXC_INT, 1);
      for (int i = 0; i < 3; i++) cyc(2'b11, 32'h7000 + 32'(8 * i), EXC_INT, 0);
      cyc(2'b11, 32'h7018, EXC_INT, 1, 0, 1);
      cyc(2'b00, 32'h0, EXC_INT, 1);
      for (int i = 0; i < 3; i++) cyc(2'b11, 32'h9000 + 32'(8 * i), EXC_INT, 0);
      cyc(2'b00, 32'h0, EXC_INT, 1);
      @(posedge clk);
      #3 rst = 1;
      mq.delete();
      #1;
      chk("async_rst valid_F", 128'(valid_F), 128'(0));
      chk("async_rst instr_F", 128'(instr_F), 128'(0));
      chk("async_rst in_ready", 128'(in_ready), 128'(1));
      in_valid = 0;
      cyc(2'b00, 32'h0, EXC_INT, 1);
      #1 rst = 0;
      pcn = 32'h8000;
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) pcn = {$urandom_range(0, 32'hffff), 3'b000};
         cyc(2'($urandom_range(0, 3)), pcn, ($urandom_range(0, 9) == 0) ? EXC_ADEL : EXC_INT,
             $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0,
             $urandom_range(0, 15) == 0);
         pcn = pcn + 32'd8;
      end
      repeat (6) cyc(2'b00, 32'h0, EXC_INT, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Fetch-side instruction queue; the producing end of the fetch→decode handshake (instr_F/valid_F/pc_F/bp_info_F/exc_code_F/tre_F, allowin_D, recover_decode).
- Accepts 2-slot fetch groups from the I-cache stage and buffers them per instruction.
- Emits decode packets of 1–2 instructions, pairing two instructions only when they are PC-consecutive and share exception status.
- Flushed by backend flush or by a decode-stage branch-prediction recovery.

Parameters:
- DEPTH, 8, queue entries (one instruction each); power of two, ≥4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  backend flush; clears queue
- recover_decode  in  Recover_Decode_S  decode redirect; .Vaild clears queue
- in_valid  in  2  slot valid of incoming group; bit0 = pc, bit1 = pc+4
- in_instr  in  64  [31:0] slot0, [63:32] slot1
- in_pc  in  32  slot0 address, pc[2]=0
- in_bp_info  in  Predict_Branch_S[1:0]  per-slot prediction
- in_exc_code  in  5  group exception code (`Int = none)
- in_tre  in  1  group TLB-refill flag
- in_ready  out  1  queue can accept a group this cycle
- allowin_D  in  1  decode accepts the presented packet
- valid_F  out  2  packet slot valid: 2'b00, 2'b01 or 2'b11 only
- instr_F  out  64  packet instructions
- pc_F  out  32  address of packet slot0; slot1 is implicitly pc_F+4
- bp_info_F  out  Predict_Branch_S[1:0]  per-slot prediction
- exc_code_F  out  5  packet exception code
- tre_F  out  1  packet TLB-refill flag

Behaviour:
- Reset: queue empty, pointers 0. Outputs: valid_F=0, instr_F=0, pc_F=0, bp_info_F=0, exc_code_F=0, tre_F=0, in_ready=1.
- Entry fields: instr, pc, bp_info, exc_code, tre. Head/tail pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.
- Enqueue:
  - Occurs when in_ready && |in_valid.
  - Valid slots are written in order, compacted, at the tail.
  - The slot1 entry gets pc=in_pc+4.
  - Both entries get the group's exc_code and tre.
  - in_valid=2'b10 enqueues one entry with pc=in_pc+4.
- in_ready = (DEPTH − count) ≥ 2, computed from registered count only. A same-cycle dequeue does not raise it.
- Output is combinational from the head entries (no bubble latency).
  - valid_F[0] = count≥1.
  - valid_F[1] requires all of: count≥2, e1.pc==e0.pc+4, e1.exc_code==e0.exc_code, and e1.tre==e0.tre.
  - Unpaired slot1 fields are driven 0.
  - pc_F/exc_code_F/tre_F are taken from e0.
- Dequeue: when allowin_D, pop popcount(valid_F) entries (0, 1 or 2). Simultaneous enqueue and dequeue update count by the net difference.
- Flush (flush | recover_decode.Vaild):
  - Highest priority. Next cycle count=0 and pointers=0.
  - The same-cycle enqueue is dropped. The same-cycle dequeue is irrelevant.
  - Outputs drop to 0 the following cycle.
- Full: count==DEPTH−1 or DEPTH gives in_ready=0. Entries are never overwritten.
- Empty: valid_F=0. allowin_D is ignored.
- Reset mid-operation clears all state immediately (async).

Optional Feature:
- FETCH_QUEUE_BYPASS_EN
  - Defined: when the queue is empty, in_ready is high, allowin_D is high and no flush is active, the incoming group is presented combinationally on the outputs that cycle, with the same pairing rules. Accepted instructions are not enqueued; unaccepted ones are enqueued normally.
  - Undefined: every instruction is registered first, giving a minimum of 1 cycle from in_valid to valid_F.

Decomposition:
- Shared package (fetch_pkg):
  - fq_entry_t struct: instr, pc, bp_info, exc_code, tre.
  - `Int and exc-code constants.
  - Existing Predict_Branch_S and Recover_Decode_S.
- Sub-module fq_pair_select: combinational; takes head entries e0/e1 and count, produces the valid_F/packet fields.

Test Plan:
- Enqueue in_pc=0x1000, in_valid=11, allowin_D=1 → next cycle valid_F=11, pc_F=0x1000, instr_F={I1,I0}. Following cycle the queue is empty and valid_F=00.
- Group in_pc=0x2000, in_valid=10 → one entry with pc 0x2004. Presented as valid_F=01, pc_F=0x2004.
- Entries pc 0x3004 then 0x4000 (redirect) → two separate packets, each valid_F=01.
- Entry with exc_code=`Int followed by one with exc_code=AdEL at consecutive PCs → not paired. The second packet carries exc_code_F=AdEL.
- DEPTH=8, allowin_D=0, four groups of 2 → in_ready falls after count reaches 8 (actually after 7 or 8 entries). A fifth group held is never lost. Raising allowin_D drains 2 per cycle.
- recover_decode.Vaild=1 with 6 entries and a concurrent enqueue → next cycle count=0, valid_F=00, in_ready=1.
- Assert rst asynchronously mid-drain → outputs 0 without a clock edge.
